// File: rtl/camera_cfg_sequencer.sv
// camera_cfg_sequencer: power-up and register-load sequencer for an SCCB camera.
// Holds the sensor in hardware reset, waits for its supply to settle, then offers
// each entry of an internal configuration ROM to an external SCCB sender.
// Entry 0 is the soft-reset write. The sensor is given a settle window after it
// before the rest of the table is offered.
// Optional feature macro: CAM_CFG_RETRIGGER_EN adds a reconfig input that replays
// the table from DONE without pulsing the camera hardware reset.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RST_HOLD | cam_rst_n held low, counting the hardware reset pulse
// PWR_WAIT | cam_rst_n released, waiting before the first write
// SEND     | entry cfg_index offered (cfg_ok=1) until sccb_ok
// SETTLE   | soft-reset entry accepted, waiting for the sensor to reboot
// DRAIN    | last entry accepted, waiting for its transfer to finish
// DONE     | table fully written, cfg_done held high

module camera_cfg_sequencer #(
  parameter int TABLE_LEN       = 16,
  parameter int RST_HOLD_CYCLES = 25000,
  parameter int PWR_WAIT_CYCLES = 500000,
  parameter int SETTLE_CYCLES   = 262144,
  parameter int XFER_CYCLES     = 65536
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sccb_ok,
`ifdef CAM_CFG_RETRIGGER_EN
  input  logic       reconfig,
`endif
  output logic       cfg_ok,
  output logic [7:0] reg_addr,
  output logic [7:0] value,
  output logic       cam_rst_n,
  output logic       cam_pwdn,
  output logic [7:0] cfg_index,
  output logic       cfg_done
);

  typedef enum logic [2:0] {
    RST_HOLD = 3'd0,
    PWR_WAIT = 3'd1,
    SEND     = 3'd2,
    SETTLE   = 3'd3,
    DRAIN    = 3'd4,
    DONE     = 3'd5
  } state_t;

  // Counter load values are "cycles - 1": the state exits on the edge that sees zero.
  localparam logic [23:0] RST_LOAD    = 24'(RST_HOLD_CYCLES - 1);
  localparam logic [23:0] PWR_LOAD    = 24'(PWR_WAIT_CYCLES - 1);
  localparam logic [23:0] SETTLE_LOAD = 24'(SETTLE_CYCLES - 1);
  localparam logic [23:0] XFER_LOAD   = 24'(XFER_CYCLES - 1);
  localparam logic [7:0]  TBL_LEN8    = 8'(TABLE_LEN);
  localparam logic [7:0]  LAST_IDX    = 8'(TABLE_LEN - 1);

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [7:0]  idx_q, idx_d;
  logic        ok_q, ok_d;
  logic        rst_n_q, rst_n_d;
  logic        done_q, done_d;
  logic        pwdn_q;
  logic [15:0] rom_word;
  logic        cnt_zero;

  assign cnt_zero = (cnt_q == 24'd0);

  // Configuration ROM, {addr, data}; entries past the built-in list read as the FF/FF end marker.
  always_comb begin
    rom_word = 16'hFFFF;
    if (idx_q < TBL_LEN8) begin
      case (idx_q)
        8'd0:    rom_word = 16'h1280;
        8'd1:    rom_word = 16'h1101;
        8'd2:    rom_word = 16'h0C00;
        8'd3:    rom_word = 16'h3E00;
        8'd4:    rom_word = 16'h40D0;
        8'd5:    rom_word = 16'h3A04;
        8'd6:    rom_word = 16'h1418;
        8'd7:    rom_word = 16'h4FB3;
        8'd8:    rom_word = 16'h50B3;
        8'd9:    rom_word = 16'h5100;
        8'd10:   rom_word = 16'h523D;
        8'd11:   rom_word = 16'h53A7;
        8'd12:   rom_word = 16'h54E4;
        8'd13:   rom_word = 16'h589E;
        8'd14:   rom_word = 16'h3DC0;
        8'd15:   rom_word = 16'h1714;
        default: rom_word = 16'hFFFF;
      endcase
    end
  end

  // Next-state, shared down-counter and registered output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ok_d    = ok_q;
    rst_n_d = rst_n_q;
    done_d  = done_q;
    case (state_q)
      RST_HOLD: begin
        if (cnt_zero) begin
          rst_n_d = 1'b1;
          cnt_d   = PWR_LOAD;
          state_d = PWR_WAIT;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      PWR_WAIT: begin
        if (cnt_zero) begin
          idx_d   = 8'd0;
          ok_d    = 1'b1;
          state_d = SEND;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      SEND: begin
        if (sccb_ok) begin
          // Soft reset is checked first so a one-entry table still gets its settle time.
          if (idx_q == 8'd0) begin
            ok_d    = 1'b0;
            cnt_d   = SETTLE_LOAD;
            state_d = SETTLE;
          end else if (idx_q == LAST_IDX) begin
            ok_d    = 1'b0;
            cnt_d   = XFER_LOAD;
            state_d = DRAIN;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      SETTLE: begin
        if (cnt_zero) begin
          if (TABLE_LEN == 1) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            idx_d   = 8'd1;
            ok_d    = 1'b1;
            state_d = SEND;
          end
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      DRAIN: begin
        if (cnt_zero) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      DONE: begin
`ifdef CAM_CFG_RETRIGGER_EN
        if (reconfig) begin
          done_d  = 1'b0;
          idx_d   = 8'd0;
          ok_d    = 1'b1;
          state_d = SEND;
        end
`endif
      end
      default: begin
        state_d = RST_HOLD;
        cnt_d   = RST_LOAD;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RST_HOLD;
      cnt_q   <= RST_LOAD;
      idx_q   <= 8'd0;
      ok_q    <= 1'b0;
      rst_n_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ok_q    <= ok_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
    end
  end

  // Power-down follows reset by one cycle so the sensor is parked while we are held.
  always_ff @(posedge clk) begin
    pwdn_q <= reset;
  end

  assign cfg_ok    = ok_q;
  assign reg_addr  = ok_q ? rom_word[15:8] : 8'h00;
  assign value     = ok_q ? rom_word[7:0]  : 8'h00;
  assign cam_rst_n = rst_n_q;
  assign cam_pwdn  = pwdn_q;
  assign cfg_index = idx_q;
  assign cfg_done  = done_q;

endmodule
